mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Multi-cycle signed multiply/divide unit for the MIPS multi-cycle datapath. It executes mult and div on two register-file operands. Its hi/lo outputs drive the HI and LO sources of the register write-back select mux, which backs mfhi/mflo. The control FSM starts an operation and waits for done; div-by-zero is reported to exception control.

Parameters:
WIDTH, 32, operand/result width. Only 32 is supported.
ITER, 32, iterations per operation. Must equal WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
a  input  WIDTH  rs operand (multiplicand / dividend), signed
b  input  WIDTH  rt operand (multiplier / divisor), signed
mult_start  input  1  start signed multiply; sampled only in IDLE
div_start  input  1  start signed divide; sampled only in IDLE
hi  output  WIDTH  mult: product[63:32]; div: remainder
lo  output  WIDTH  mult: product[31:0]; div: quotient
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse on the cycle hi/lo take new results
div_zero  output  1  one-cycle pulse when div_start is seen with b == 0

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on reset.
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, state = IDLE, counter = 0.
- FSM states: IDLE, MULT, DIV, FINISH.
- IDLE:
  - mult_start at edge T: latch a and b, go to MULT, busy = 1 from T+1.
  - div_start with b != 0: latch a and b, go to DIV.
  - div_start with b == 0: div_zero = 1 at T+1 only; stay in IDLE; hi/lo unchanged; busy stays 0.
  - mult_start and div_start together: mult wins; div_start is ignored.
- MULT: radix-2 Booth, one step per cycle, ITER steps.
  - 65-bit accumulator {A, Q, q-1}.
  - Arithmetic right shift each step.
- DIV: restoring division on magnitudes, one step per cycle, ITER steps.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a), C-style truncation toward zero.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0. No overflow flag.
- FINISH: write hi/lo, done = 1 for one cycle, busy = 0, return to IDLE.
- Latency: start accepted at edge T; results and done visible at T+33.
- The next start is accepted at the edge where done is high; back-to-back gap is 0 cycles.
- Starts while busy are ignored; they are not queued.
- Operands are changed only by latching at start; a and b changes mid-operation have no effect.
- hi/lo hold their values between operations; they change only in FINISH or on reset.
- Reset mid-operation aborts at the next edge: outputs return to reset values and no done is issued.
- The counter is a 6-bit down-counter loaded with ITER; the iterate state exits when it reaches 0, with no wrap.

Decomposition:
- Package mips_md_pkg holds:
  - md_state_t enum {IDLE, MULT, DIV, FINISH}
  - MD_WIDTH = 32
  - MD_ITER = 32
  - MD_CNT_W = 6
- One natural sub-module: md_booth_step, a combinational single Booth add/sub-and-shift on the 65-bit accumulator.
- The division step stays inline in mult_div_unit.

Test Plan:
- mult a=7, b=-3 (0xFFFFFFFD) -> at T+33 hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse of 1 cycle, busy high T+1..T+32.
- mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
- div 100/7 -> lo=14, hi=2. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/-1 -> lo=0x80000000, hi=0.
- div_start with a=5, b=0 after a prior mult -> div_zero pulse at T+1, busy stays 0, hi/lo keep the prior mult result, no done.
- Start collisions:
  - mult_start at T+5 during a running div is ignored; the div result is unchanged.
  - mult_start and div_start together in IDLE -> multiply result.
  - A new start on the done cycle is accepted.
- reset asserted at T+10 of a mult -> next cycle hi=lo=0, busy=0; done never pulses for that operation.

Source files
------------

// File: rtl/mips_md_pkg.sv
// mips_md_pkg
// Shared types and constants for the multi-cycle signed multiply/divide unit.
//   md_state_t : control FSM states
//   MD_WIDTH   : operand/result width
//   MD_ITER    : iterations per operation (one bit per cycle)
//   MD_CNT_W   : width of the iteration down-counter (must hold MD_ITER)
package mips_md_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } md_state_t;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 6;

endpackage

// File: rtl/md_booth_step.sv
// md_booth_step
// Combinational single radix-2 Booth step on the {A, Q, q-1} accumulator:
// conditional add/subtract of the multiplicand into A, then an arithmetic
// right shift of the whole accumulator by one bit.
//   i_acc          : current accumulator {A[WIDTH-1:0], Q[WIDTH-1:0], q-1}
//   i_multiplicand : signed multiplicand M
//   o_acc          : accumulator after one Booth step
module md_booth_step
  import mips_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_multiplicand,
  output logic [2*WIDTH:0] o_acc
);

  logic [WIDTH:0] w_aExt;
  logic [WIDTH:0] w_mExt;
  logic [WIDTH:0] w_sum;

  // A and M are widened by one sign bit so that subtracting the most
  // negative multiplicand cannot overflow before the shift. The shift then
  // drops the sum's LSB into Q, and the extra sign bit becomes the new top
  // of A, which is exactly an arithmetic right shift of the 66-bit value.
  always_comb begin
    w_aExt = {i_acc[2*WIDTH], i_acc[2*WIDTH:WIDTH+1]};
    w_mExt = {i_multiplicand[WIDTH-1], i_multiplicand};
    case (i_acc[1:0])
      2'b01:   w_sum = w_aExt + w_mExt;
      2'b10:   w_sum = w_aExt - w_mExt;
      default: w_sum = w_aExt;
    endcase
    o_acc = {w_sum, i_acc[WIDTH:1]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Multi-cycle signed multiply/divide unit for the MIPS multi-cycle datapath.
// Multiply uses radix-2 Booth, divide uses restoring division on magnitudes
// with C-style truncation toward zero. One bit per cycle, ITER cycles.
//   clk, reset            : clock, synchronous active-high reset
//   a, b                  : rs / rt operands (signed), latched at start
//   mult_start, div_start : start requests, only honoured in IDLE
//   hi, lo                : mult {hi,lo} = product; div hi = rem, lo = quot
//   busy                  : operation in progress
//   done                  : one-cycle pulse when hi/lo take new results
//   div_zero              : one-cycle pulse when a divide by zero is refused
module mult_div_unit
  import mips_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mult_start,
  input  logic             div_start,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  md_state_t             r_state;
  logic [MD_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]      r_acc;
  logic [WIDTH-1:0]      r_m;
  logic [WIDTH-1:0]      r_rem;
  logic [WIDTH-1:0]      r_quo;
  logic                  r_isDiv;
  logic                  r_negQ;
  logic                  r_negR;

  logic [2*WIDTH:0]      w_accNext;
  logic [WIDTH-1:0]      w_aMag;
  logic [WIDTH-1:0]      w_bMag;
  logic [WIDTH:0]        w_remShift;
  logic [WIDTH-1:0]      w_remSub;
  logic                  w_remFits;

  md_booth_step #(
    .WIDTH(WIDTH)
  ) u_booth (
    .i_acc         (r_acc),
    .i_multiplicand(r_m),
    .o_acc         (w_accNext)
  );

  // Operand magnitudes for the divider. The most negative value maps to
  // itself, which read as unsigned is the correct magnitude 2^(WIDTH-1).
  // One restoring step shifts the next dividend bit into the partial
  // remainder and subtracts the divisor if it fits. The remainder is always
  // below the divisor, so the shifted value needs only one extra bit and the
  // low WIDTH bits of the difference are exact whenever it fits.
  always_comb begin
    w_aMag     = a[WIDTH-1] ? -a : a;
    w_bMag     = b[WIDTH-1] ? -b : b;
    w_remShift = {r_rem, r_quo[WIDTH-1]};
    w_remFits  = (w_remShift >= {1'b0, r_m});
    w_remSub   = w_remShift[WIDTH-1:0] - r_m;
  end

  // Control FSM with all outputs registered. done and div_zero default low
  // so they can only ever be single-cycle pulses. The iteration counter is
  // loaded with ITER on start and the iterate state leaves on the step that
  // takes it to zero, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_isDiv  <= 1'b0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mult_start) begin
            r_acc   <= {{WIDTH{1'b0}}, b, 1'b0};
            r_m     <= a;
            r_isDiv <= 1'b0;
            r_cnt   <= MD_CNT_W'(ITER);
            busy    <= 1'b1;
            r_state <= MULT;
          end else if (div_start) begin
            if (b == '0) begin
              div_zero <= 1'b1;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_aMag;
              r_m     <= w_bMag;
              r_negQ  <= a[WIDTH-1] ^ b[WIDTH-1];
              r_negR  <= a[WIDTH-1];
              r_isDiv <= 1'b1;
              r_cnt   <= MD_CNT_W'(ITER);
              busy    <= 1'b1;
              r_state <= DIV;
            end
          end
        end
        MULT: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt - MD_CNT_W'(1);
          if (r_cnt == MD_CNT_W'(1)) begin
            r_state <= FINISH;
          end
        end
        DIV: begin
          if (w_remFits) begin
            r_rem <= w_remSub;
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_remShift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - MD_CNT_W'(1);
          if (r_cnt == MD_CNT_W'(1)) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          if (r_isDiv) begin
            hi <= r_negR ? -r_rem : r_rem;
            lo <= r_negQ ? -r_quo : r_quo;
          end else begin
            hi <= r_acc[2*WIDTH:WIDTH+1];
            lo <= r_acc[WIDTH:1];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Directed-vector bench for mult_div_unit. Expected values are hand-computed
// constants. Outputs are sampled on the falling edge, inputs driven so that
// they are stable at the rising edge.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        mult_start;
  logic        div_start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int vectorCount;
  int miscompareCount;

  mult_div_unit #(
    .WIDTH(32),
    .ITER (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .mult_start(mult_start),
    .div_start (div_start),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: presents a start request for exactly one rising
  // edge (edge T), then scrambles the operands so latching is exercised.
  task automatic applyStimulus(input logic ms, input logic ds,
                               input logic [31:0] av, input logic [31:0] bv);
    a          = av;
    b          = bv;
    mult_start = ms;
    div_start  = ds;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = 32'hDEAD_BEEF;
    b          = 32'h1234_5678;
  endtask

  // Follows an accepted operation from edge T to the result at T+33.
  // busy must be high and done low after edges T..T+32, then the result
  // cycle must show done=1, busy=0 and the expected hi/lo. injectAt >= 0
  // presents a mult_start that is sampled at edge T+injectAt+1.
  // Returns at the falling edge of the done cycle.
  task automatic waitResult(input string tag, input logic [31:0] expHi,
                            input logic [31:0] expLo, input int injectAt);
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      mult_start = 1'b0;
      checkOutput({tag, " busy/done"}, {30'd0, busy, done}, 32'd2);
      if (i == injectAt) begin
        a          = 32'd3;
        b          = 32'd3;
        mult_start = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    mult_start = 1'b0;
    checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " hi"}, hi, expHi);
    checkOutput({tag, " lo"}, lo, expLo);
  endtask

  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    reset           = 1'b1;
    a               = '0;
    b               = '0;
    mult_start      = 1'b0;
    div_start       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst hi", hi, 32'd0);
    checkOutput("rst lo", lo, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst done", {31'd0, done}, 32'd0);
    checkOutput("rst div_zero", {31'd0, div_zero}, 32'd0);

    // 7 * -3 = -21, then two back-to-back multiplies started on the done cycle
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    waitResult("mul 7*-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    waitResult("mul min*min", 32'h4000_0000, 32'h0000_0000, -1);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResult("mul -1*-1", 32'h0000_0000, 32'h0000_0001, -1);

    // done is a single-cycle pulse
    @(negedge clk);
    checkOutput("done pulse width", {31'd0, done}, 32'd0);

    // Signed divides
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    waitResult("div 100/7", 32'd2, 32'd14, -1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    waitResult("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitResult("div min/-1", 32'h0000_0000, 32'h8000_0000, -1);

    // Divide by zero after a multiply: flag only, hi/lo untouched
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd6);
    waitResult("mul 5*6", 32'd0, 32'd30, -1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
    @(negedge clk);
    checkOutput("dz flag", {31'd0, div_zero}, 32'd1);
    checkOutput("dz busy", {31'd0, busy}, 32'd0);
    checkOutput("dz done", {31'd0, done}, 32'd0);
    checkOutput("dz hi", hi, 32'd0);
    checkOutput("dz lo", lo, 32'd30);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("dz after", {29'd0, div_zero, busy, done}, 32'd0);
    end
    checkOutput("dz lo hold", lo, 32'd30);

    // mult_start at T+5 of a running divide is ignored
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    waitResult("div ignore mul", 32'd2, 32'd14, 4);

    // Both starts together: multiply wins (6*4 = 24; 6/4 would be 1 r 2)
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'd6, 32'd4);
    waitResult("mul+div", 32'd0, 32'd24, -1);

    // Reset at T+10 of a multiply aborts it with no done
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checkOutput("abort no done", {30'd0, busy, done}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
